// File: rtl/serial_paralelo_if.sv
// serial_paralelo_if: serial line input plus recovered-word outputs of the
// deserializer. The slave side is the deserializer itself; the master side is
// whatever drives the line and consumes the words.
interface serial_paralelo_if #(
    parameter int cantidadBits = 10
);
    logic                    entrada;
    logic [cantidadBits-1:0] salida;
    logic                    valido;
    logic                    es_coma;
    logic                    alineado;
    logic                    realineado;

    modport master (
        output entrada,
        input  salida,
        input  valido,
        input  es_coma,
        input  alineado,
        input  realineado
    );

    modport slave (
        input  entrada,
        output salida,
        output valido,
        output es_coma,
        output alineado,
        output realineado
    );
endinterface

// File: rtl/serial_paralelo.sv
// serial_paralelo: serial-to-parallel deserializer with K28.5 comma alignment.
// Shifts in one line bit per clock (first bit of a word lands in word bit 0),
// locks the 10-bit boundary on the first comma and presents each word with a
// one-cycle valid strobe. Once aligned it only moves the boundary after
// MAX_DESALINEOS consecutive off-boundary commas, so a single corrupted bit
// pattern in data cannot knock the link out of alignment.
module serial_paralelo #(
    parameter int                       cantidadBits   = 10,
    parameter logic [cantidadBits-1:0]  COMA_NEG       = 10'b0101111100,
    parameter logic [cantidadBits-1:0]  COMA_POS       = 10'b1010000011,
    parameter int                       MAX_DESALINEOS = 2
) (
    input  logic              clk,
    input  logic              reset,
    serial_paralelo_if.slave  bus
);

    localparam logic [0:0] BUSCANDO = 1'b0;
    localparam logic [0:0] ALINEADO = 1'b1;

    // Phase value meaning "sr holds a complete word on the current boundary".
    localparam logic [3:0] FASE_LLENA = 4'(cantidadBits);
    localparam logic [4:0] LIMITE     = 5'(MAX_DESALINEOS);

    logic [0:0]              estado;
    logic [cantidadBits-1:0] sr;
    logic [cantidadBits-1:0] salida_r;
    logic                    valido_r;
    logic                    es_coma_r;
    logic                    realineado_r;
    logic [3:0]              fase;
    logic [3:0]              cuenta;

    logic                    coma;
    logic [4:0]              cuenta_sig;

    // Comma detection and the would-be miss count, both on sr before the edge.
    always_comb begin
        coma       = (sr == COMA_NEG) || (sr == COMA_POS);
        cuenta_sig = {1'b0, cuenta} + 5'd1;
    end

    // Shift register, alignment state machine and registered word outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= BUSCANDO;
            sr           <= '0;
            salida_r     <= '0;
            valido_r     <= 1'b0;
            es_coma_r    <= 1'b0;
            realineado_r <= 1'b0;
            fase         <= 4'd0;
            cuenta       <= 4'd0;
        end else begin
            sr           <= {bus.entrada, sr[cantidadBits-1:1]};
            valido_r     <= 1'b0;
            realineado_r <= 1'b0;

            if (estado == BUSCANDO) begin
                fase   <= 4'd0;
                cuenta <= 4'd0;
                if (coma) begin
                    salida_r  <= sr;
                    valido_r  <= 1'b1;
                    es_coma_r <= 1'b1;
                    fase      <= 4'd1;
                    estado    <= ALINEADO;
                end
            end else if (fase == FASE_LLENA) begin
                salida_r  <= sr;
                valido_r  <= 1'b1;
                es_coma_r <= coma;
                fase      <= 4'd1;
                if (coma) begin
                    cuenta <= 4'd0;
                end
            end else begin
                fase <= fase + 4'd1;
                if (coma) begin
                    if (cuenta_sig < LIMITE) begin
                        cuenta <= cuenta_sig[3:0];
                    end else begin
                        salida_r     <= sr;
                        valido_r     <= 1'b1;
                        es_coma_r    <= 1'b1;
                        realineado_r <= 1'b1;
                        fase         <= 4'd1;
                        cuenta       <= 4'd0;
                    end
                end
            end
        end
    end

    assign bus.salida     = salida_r;
    assign bus.valido     = valido_r;
    assign bus.es_coma    = es_coma_r;
    assign bus.alineado   = (estado == ALINEADO);
    assign bus.realineado = realineado_r;

endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: directed bench for the comma-aligning deserializer.
// Bits are driven 1 time unit after each rising edge and outputs are sampled
// at the same point, so each sample reflects the edge that just consumed the
// previous bit. Pulse indices below are the index of the bit whose edge made
// the pulse visible, counted from the end of reset.
module tb_serial_paralelo;

    localparam logic [9:0] COMA_NEG = 10'h17C;
    localparam logic [9:0] COMA_POS = 10'h283;
    localparam logic [9:0] DATO_A   = 10'h155;
    localparam logic [9:0] DATO_B   = 10'h2AA;
    // One filler 0 followed by the first 9 bits of COMA_NEG.
    localparam logic [9:0] BASURA   = 10'h2F8;

    logic clk = 1'b0;
    logic reset;

    serial_paralelo_if #(.cantidadBits(10)) bus ();

    serial_paralelo #(
        .cantidadBits  (10),
        .COMA_NEG      (COMA_NEG),
        .COMA_POS      (COMA_POS),
        .MAX_DESALINEOS(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ciclo;
        logic [9:0] salida;
        logic       es_coma;
        logic       alineado;
        logic       realineado;
    } pulso_t;

    typedef struct {
        logic       entrada;
        logic [9:0] salida;
        logic       valido;
        logic       es_coma;
        logic       alineado;
    } vector_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     realin_sueltos = 0;
    pulso_t vistos[$];
    pulso_t esperados[$];

    // Drive one line bit, step one clock and log any valid pulse.
    task automatic applyStimulus(input logic b);
        bus.entrada = b;
        @(posedge clk);
        #1;
        if (bus.valido) begin
            vistos.push_back('{cyc, bus.salida, bus.es_coma, bus.alineado, bus.realineado});
        end else if (bus.realineado) begin
            realin_sueltos++;
        end
        cyc++;
    endtask

    task automatic checkOutput(input string nombre, input logic [31:0] actual,
                               input logic [31:0] esperado);
        checks++;
        if (actual !== esperado) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nombre, actual, esperado);
        end
    endtask

    task automatic sendWord(input logic [9:0] w);
        for (int i = 0; i < 10; i++) applyStimulus(w[i]);
    endtask

    task automatic startTest();
        reset = 1'b1;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        reset = 1'b0;
        cyc = 0;
        realin_sueltos = 0;
        vistos.delete();
        esperados.delete();
    endtask

    task automatic addEsperado(input int ciclo, input logic [9:0] salida,
                               input logic es_coma, input logic realineado);
        esperados.push_back('{ciclo, salida, es_coma, 1'b1, realineado});
    endtask

    // Compare the logged valid pulses against the hand-built expectation list.
    task automatic checkPulses(input string nombre);
        int n;
        checkOutput($sformatf("%s pulse count", nombre), vistos.size(), esperados.size());
        n = (vistos.size() < esperados.size()) ? vistos.size() : esperados.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s p%0d cycle", nombre, i), vistos[i].ciclo, esperados[i].ciclo);
            checkOutput($sformatf("%s p%0d salida", nombre, i), vistos[i].salida, esperados[i].salida);
            checkOutput($sformatf("%s p%0d es_coma", nombre, i), vistos[i].es_coma, esperados[i].es_coma);
            checkOutput($sformatf("%s p%0d alineado", nombre, i), vistos[i].alineado, esperados[i].alineado);
            checkOutput($sformatf("%s p%0d realineado", nombre, i), vistos[i].realineado, esperados[i].realineado);
        end
        checkOutput($sformatf("%s stray realineado", nombre), realin_sueltos, 0);
    endtask

    function automatic logic [13:0] snapshot();
        return {bus.salida, bus.valido, bus.es_coma, bus.alineado, bus.realineado};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t    tabla[34];
        logic [9:0] coma_v;
        logic [9:0] dato_v;

        bus.entrada = 1'b0;
        reset = 1'b1;

        // ---------------- Reset and idle line ----------------
        $display("[TB] reset and idle line");
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("reset outputs", snapshot(), 14'h0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("idle c%0d", i), snapshot(), 14'h0);
        end

        // ---------------- First lock, table driven ----------------
        $display("[TB] first lock on COMA_NEG then 0x155");
        coma_v = COMA_NEG;
        dato_v = DATO_A;
        for (int i = 0; i < 34; i++) begin
            if (i < 3)       tabla[i].entrada = 1'b0;
            else if (i < 13) tabla[i].entrada = coma_v[i-3];
            else if (i < 23) tabla[i].entrada = dato_v[i-13];
            else             tabla[i].entrada = 1'b0;

            if (i < 13)       tabla[i] = '{tabla[i].entrada, 10'h000, 1'b0, 1'b0, 1'b0};
            else if (i == 13) tabla[i] = '{tabla[i].entrada, 10'h17C, 1'b1, 1'b1, 1'b1};
            else if (i < 23)  tabla[i] = '{tabla[i].entrada, 10'h17C, 1'b0, 1'b1, 1'b1};
            else if (i == 23) tabla[i] = '{tabla[i].entrada, 10'h155, 1'b1, 1'b0, 1'b1};
            else if (i < 33)  tabla[i] = '{tabla[i].entrada, 10'h155, 1'b0, 1'b0, 1'b1};
            else              tabla[i] = '{tabla[i].entrada, 10'h000, 1'b1, 1'b0, 1'b1};
        end
        startTest();
        for (int i = 0; i < 34; i++) begin
            applyStimulus(tabla[i].entrada);
            checkOutput($sformatf("lock c%0d", i), snapshot(),
                        {tabla[i].salida, tabla[i].valido, tabla[i].es_coma,
                         tabla[i].alineado, 1'b0});
        end

        // ---------------- Steady aligned stream ----------------
        $display("[TB] 20 alternating COMA_POS / 0x2AA words");
        startTest();
        for (int w = 0; w < 20; w++) begin
            sendWord((w % 2 == 0) ? COMA_POS : DATO_B);
            addEsperado(10 + 10 * w, (w % 2 == 0) ? COMA_POS : DATO_B, (w % 2 == 0), 1'b0);
        end
        applyStimulus(1'b0);
        checkPulses("stream");

        // ---------------- Realign after two shifted commas ----------------
        $display("[TB] extra bit then two shifted commas");
        startTest();
        sendWord(COMA_NEG);
        sendWord(DATO_A);
        applyStimulus(1'b0);
        sendWord(COMA_NEG);
        sendWord(COMA_NEG);
        sendWord(DATO_A);
        applyStimulus(1'b0);
        addEsperado(10, COMA_NEG, 1'b1, 1'b0);
        addEsperado(20, DATO_A,   1'b0, 1'b0);
        addEsperado(30, BASURA,   1'b0, 1'b0);
        addEsperado(40, BASURA,   1'b0, 1'b0);
        addEsperado(41, COMA_NEG, 1'b1, 1'b1);
        addEsperado(51, DATO_A,   1'b0, 1'b0);
        checkPulses("realign");

        // ---------------- Aligned comma clears the miss count ----------------
        $display("[TB] shifted, aligned, shifted comma");
        startTest();
        sendWord(COMA_NEG);
        applyStimulus(1'b0);
        sendWord(COMA_NEG);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0);
        sendWord(COMA_NEG);
        applyStimulus(1'b0);
        sendWord(COMA_NEG);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0);
        addEsperado(10, COMA_NEG, 1'b1, 1'b0);
        addEsperado(20, BASURA,   1'b0, 1'b0);
        addEsperado(30, 10'h000,  1'b0, 1'b0);
        addEsperado(40, COMA_NEG, 1'b1, 1'b0);
        addEsperado(50, BASURA,   1'b0, 1'b0);
        addEsperado(60, 10'h000,  1'b0, 1'b0);
        checkPulses("miss clear");

        // ---------------- Reset mid-word, then relock ----------------
        $display("[TB] reset at fase 5 then relock on COMA_POS");
        startTest();
        sendWord(COMA_NEG);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0);
        reset = 1'b1;
        applyStimulus(1'b1);
        checkOutput("mid-word reset outputs", snapshot(), 14'h0);
        reset = 1'b0;
        sendWord(COMA_POS);
        applyStimulus(1'b0);
        addEsperado(10, COMA_NEG, 1'b1, 1'b0);
        addEsperado(26, COMA_POS, 1'b1, 1'b0);
        checkPulses("relock");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
